// File: rtl/serial_pad_reader.sv
// rtl/serial_pad_reader.sv - polls N_PADS NES/SNES serial pads over a shared latch/clock pair (optional SERIAL_PAD_DEBOUNCE_EN)
module serial_pad_reader #(
    parameter int N_BITS      = 8,
    parameter int N_PADS      = 2,
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       start,
    input  logic [N_PADS-1:0]          pad_data,
    output logic                       pad_latch,
    output logic                       pad_clk,
    output logic                       busy,
    output logic                       valid,
    output logic [N_PADS*N_BITS-1:0]   buttons,
    output logic [N_PADS*N_BITS-1:0]   pressed
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int IW = $clog2(N_BITS);
    localparam int TW = $clog2(POLL_PERIOD);
    localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_BITS - 1);
    localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        READ_LO,
        READ_HI,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [DW-1:0]   div;
    logic            latch_half;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   timer;
    logic            poll_pend;
    logic            req_pend;
    logic            last;
    logic            launch;
    logic            wrap;
    logic            sample;

    assign last   = (div == '0);
    assign launch = (state == IDLE) && (state_n == LATCH);
    assign wrap   = en && (timer == POLL_LAST);
    assign sample = (state == READ_LO) && last;

    assign pad_latch = (state == LATCH);
    assign pad_clk   = (state != READ_LO);
    assign busy      = (state != IDLE);
    assign valid     = (state == DONE);

    // Next-state logic: LATCH spans two divider periods, then alternating low/high clock phases.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start || poll_pend || req_pend) state_n = LATCH;
            LATCH:   if (last && latch_half) state_n = READ_LO;
            READ_LO: if (last) state_n = (idx == IDX_LAST) ? DONE : READ_HI;
            READ_HI: if (last) state_n = READ_LO;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, phase divider (reloaded on each state entry) and bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            div        <= '0;
            latch_half <= 1'b0;
            idx        <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                div        <= DIV_LOAD;
                latch_half <= 1'b0;
            end else if (last) begin
                div        <= DIV_LOAD;
                latch_half <= 1'b1;
            end else begin
                div <= div - DW'(1);
            end
            if (state == LATCH)
                idx <= '0;
            else if (state == READ_HI && last)
                idx <= idx + IW'(1);
        end
    end

    // Auto-poll timer: free-runs while enabled, held at zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timer <= '0;
        else if (!en || wrap)
            timer <= '0;
        else
            timer <= timer + TW'(1);
    end

    // Pending requests: timer wraps and starts that arrive mid-frame each queue one more frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_pend <= 1'b0;
            req_pend  <= 1'b0;
        end else begin
            if (!en)
                poll_pend <= 1'b0;
            else if (wrap)
                poll_pend <= 1'b1;
            else if (launch)
                poll_pend <= 1'b0;
            if (start && state != IDLE)
                req_pend <= 1'b1;
            else if (launch)
                req_pend <= 1'b0;
        end
    end

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        logic [N_BITS-1:0] raw;
        logic [N_BITS-1:0] btn;
        logic [N_BITS-1:0] prs;

        assign buttons[p*N_BITS +: N_BITS] = btn;
        assign pressed[p*N_BITS +: N_BITS] = prs;

        // Capture the inverted pad line at the end of each low clock phase.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                raw <= '0;
            else if (sample)
                raw[idx] <= ~pad_data[p];
        end

`ifdef SERIAL_PAD_DEBOUNCE_EN
        logic [N_BITS-1:0] prev_raw;

        // Commit this pad only when two consecutive frames agree.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                prev_raw <= '0;
                btn      <= '0;
                prs      <= '0;
            end else if (state == DONE) begin
                prev_raw <= raw;
                if (raw == prev_raw) begin
                    btn <= raw;
                    prs <= raw & ~btn;
                end
            end
        end
`else
        // Commit every frame directly.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                btn <= '0;
                prs <= '0;
            end else if (state == DONE) begin
                btn <= raw;
                prs <= raw & ~btn;
            end
        end
`endif
    end

endmodule

// File: tb/tb_serial_pad_reader.sv
// tb/tb_serial_pad_reader.sv - directed self-checking bench for serial_pad_reader
module tb_serial_pad_reader;

    logic        clk;
    logic        reset;
    logic        en8;
    logic        start8;
    logic        start16;
    logic [1:0]  pd8;
    logic [1:0]  pd16;
    logic        latch8, pclk8, busy8, valid8;
    logic        latch16, pclk16, busy16, valid16;
    logic [15:0] btn8, prs8;
    logic [31:0] btn16, prs16;

    logic [7:0]  pat8 [2];
    logic [15:0] pat16 [2];
    int          cnt8, cnt16;
    logic        pq8, pq16;

    int n_tests;
    int n_fail;

    serial_pad_reader #(.N_BITS(8), .N_PADS(2), .CLK_DIV(2), .POLL_PERIOD(100)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .start(start8), .pad_data(pd8),
        .pad_latch(latch8), .pad_clk(pclk8), .busy(busy8), .valid(valid8),
        .buttons(btn8), .pressed(prs8)
    );

    serial_pad_reader #(.N_BITS(16), .N_PADS(2), .CLK_DIV(2), .POLL_PERIOD(100)) dut16 (
        .clk(clk), .reset(reset), .en(1'b0), .start(start16), .pad_data(pd16),
        .pad_latch(latch16), .pad_clk(pclk16), .busy(busy16), .valid(valid16),
        .buttons(btn16), .pressed(prs16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pad shift-register model: reload on latch, advance on each rising pad_clk.
    initial begin
        cnt8 = 0; cnt16 = 0; pq8 = 1'b1; pq16 = 1'b1;
        pd8 = 2'b11; pd16 = 2'b11;
        forever begin
            @(negedge clk);
            if (latch8) cnt8 = 0; else if (pclk8 && !pq8) cnt8++;
            if (latch16) cnt16 = 0; else if (pclk16 && !pq16) cnt16++;
            pq8 = pclk8;
            pq16 = pclk16;
            for (int p = 0; p < 2; p++) begin
                pd8[p]  = (cnt8 < 8)   ? ~pat8[p][cnt8[2:0]]   : 1'b0;
                pd16[p] = (cnt16 < 16) ? ~pat16[p][cnt16[3:0]] : 1'b0;
            end
        end
    end

    task automatic frame(input bit w16, input logic [31:0] eb, input logic [31:0] ep, input bit chk);
        int lfirst, llast, lows, vcyc;
        logic pp, lt, pc, vl;
        lfirst = -1; llast = -1; lows = 0; vcyc = -1; pp = 1'b1;
        @(negedge clk);
        if (w16) start16 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        for (int k = 1; k < 200 && vcyc < 0; k++) begin
            lt = w16 ? latch16 : latch8;
            pc = w16 ? pclk16 : pclk8;
            vl = w16 ? valid16 : valid8;
            if (lt) begin
                if (lfirst < 0) lfirst = k;
                llast = k;
            end
            if (!pc && pp) lows++;
            pp = pc;
            if (vl) vcyc = k; else @(negedge clk);
        end
        check(w16 ? "latch_first16" : "latch_first8", lfirst, 1);
        check(w16 ? "latch_last16" : "latch_last8", llast, 4);
        check(w16 ? "clk_lows16" : "clk_lows8", lows, w16 ? 16 : 8);
        check(w16 ? "valid_cyc16" : "valid_cyc8", vcyc, w16 ? 67 : 35);
        @(negedge clk);
        check("valid_one_cycle", w16 ? valid16 : valid8, 0);
        check("busy_after", w16 ? busy16 : busy8, 0);
        if (chk) begin
            check(w16 ? "buttons16" : "buttons8", w16 ? btn16 : {16'h0, btn8}, eb);
            check(w16 ? "pressed16" : "pressed8", w16 ? prs16 : {16'h0, prs8}, ep);
        end
    endtask

    task automatic set8(input logic [7:0] a, input logic [7:0] b);
        pat8[0] = a; pat8[1] = b;
    endtask

    initial begin
        int nv, v2, nr, lq;
        int rises [4];
        n_tests = 0; n_fail = 0;
        reset = 1'b0; en8 = 1'b0; start8 = 1'b0; start16 = 1'b0;
        set8(8'h00, 8'h00);
        pat16[0] = 16'h8001; pat16[1] = 16'h4000;
        repeat (3) @(negedge clk);
        check("rst_latch", latch8, 0);
        check("rst_pclk", pclk8, 1);
        check("rst_busy", busy8, 0);
        check("rst_valid", valid8, 0);
        check("rst_buttons", btn8, 0);
        check("rst_pressed", prs8, 0);
        reset = 1'b1;
        @(negedge clk);

`ifdef SERIAL_PAD_DEBOUNCE_EN
        set8(8'h00, 8'h00); frame(0, 32'h0, 32'h0, 1);
        set8(8'h01, 8'h00); frame(0, 32'h0, 32'h0, 1);
        set8(8'h00, 8'h00); frame(0, 32'h0, 32'h0, 1);
        set8(8'h01, 8'h00); frame(0, 32'h0, 32'h0, 1);
        set8(8'h01, 8'h00); frame(0, 32'h0001, 32'h0001, 1);
`else
        set8(8'h09, 8'h00); frame(0, 32'h0009, 32'h0009, 1);
        frame(0, 32'h0009, 32'h0000, 1);
        set8(8'h08, 8'h02); frame(0, 32'h0208, 32'h0200, 1);
`endif

        // Starts at cycles 10 and 20 of a frame collapse into one extra frame.
        nv = 0; v2 = -1;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        for (int k = 1; k < 160; k++) begin
            start8 = (k == 10 || k == 20);
            if (valid8) begin
                nv++;
                if (nv == 2) v2 = k;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        check("busy_start_frames", nv, 2);
        check("busy_start_valid2", v2, 71);

        // Auto-poll: frames start every POLL_PERIOD cycles.
        nr = 0; lq = 0;
        en8 = 1'b1;
        for (int k = 0; k < 350; k++) begin
            @(negedge clk);
            if (latch8 && lq == 0 && nr < 4) begin
                rises[nr] = k;
                nr++;
            end
            lq = latch8;
        end
        check("poll_rises", (nr >= 3), 1);
        check("poll_gap1", rises[1] - rises[0], 100);
        check("poll_gap2", rises[2] - rises[1], 100);

        // Drop en mid-frame: the frame in flight finishes, nothing follows.
        nv = 0;
        for (int k = 0; k < 150 && !(latch8 && !busy8 == 0 && nv == 0); k++) begin
            @(negedge clk);
            if (latch8) nv = 1;
        end
        check("poll_latch_seen", nv, 1);
        repeat (10) @(negedge clk);
        en8 = 1'b0;
        nv = 0;
        for (int k = 0; k < 250; k++) begin
            if (valid8) nv++;
            @(negedge clk);
        end
        check("en_drop_frames", nv, 1);
        check("en_drop_idle", busy8, 0);

        // Asynchronous reset 20 cycles into a frame.
        set8(8'h09, 8'h00);
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_latch", latch8, 0);
        check("midrst_pclk", pclk8, 1);
        check("midrst_busy", busy8, 0);
        check("midrst_buttons", btn8, 0);
        @(negedge clk);
        reset = 1'b1;
        nv = 0;
        for (int k = 0; k < 60; k++) begin
            if (valid8 || busy8) nv++;
            @(negedge clk);
        end
        check("midrst_no_frame", nv, 0);
`ifdef SERIAL_PAD_DEBOUNCE_EN
        frame(0, 32'h0, 32'h0, 0);
        frame(0, 32'h0009, 32'h0009, 1);
        frame(1, 32'h0, 32'h0, 0);
        frame(1, 32'h4000_8001, 32'h4000_8001, 1);
`else
        frame(0, 32'h0009, 32'h0009, 1);
        frame(1, 32'h4000_8001, 32'h4000_8001, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pad_reader.md
Name: serial_pad_reader

Overview:
- Parametrised successor to the single NES driver: polls N_PADS serial game pads (NES 8-bit or SNES 16-bit shift-register protocol) over a shared latch/clock pair with one data line per pad.
- Produces debounce-optional, active-high button vectors, per-button press-edge flags and a frame-valid strobe.
- Supports single-shot polling and auto-polling.
- Sits between the pad connectors and game/PS2-side logic in the top level.

Parameters:
- N_BITS, 8, buttons per pad (8 = NES, 16 = SNES); must be ≥2.
- N_PADS, 2, number of pads sharing pad_latch/pad_clk; must be ≥1.
- CLK_DIV, 300, clk cycles per pad_clk half-period; must be ≥1.
- POLL_PERIOD, 833333, clk cycles between auto-poll frame starts; must be ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  auto-poll enable.
- start  in  1  single-cycle request for one frame.
- pad_data  in  N_PADS  serial data from each pad; active-low, pre-synchronised.
- pad_latch  out  1  parallel-load strobe to all pads.
- pad_clk  out  1  shift clock to all pads; idles high.
- busy  out  1  high while a frame is in progress (any state other than IDLE).
- valid  out  1  one-cycle pulse: buttons/pressed updated.
- buttons  out  N_PADS*N_BITS  committed state; bit p*N_BITS+i is button i of pad p; 1 = pressed.
- pressed  out  N_PADS*N_BITS  buttons & ~previous buttons, held until the next valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - pad_latch=0, pad_clk=1, busy=0, valid=0.
  - buttons=0, pressed=0.
  - Poll timer, pending flag, bit index and divider are cleared.
  - Reset mid-frame abandons the frame: no valid, no partial commit.
- FSM states: IDLE, LATCH, READ_LO, READ_HI, DONE.
- IDLE:
  - If start=1 or pending=1, go to LATCH next cycle and clear pending.
  - Otherwise stay.
- LATCH:
  - pad_latch=1 for exactly 2*CLK_DIV cycles.
  - Then go to READ_LO with idx=0.
- READ_LO:
  - pad_clk=0 for CLK_DIV cycles.
  - On the last cycle, raw[p*N_BITS+idx] <= ~pad_data[p] for every pad.
  - If idx==N_BITS-1, go to DONE; otherwise go to READ_HI.
- READ_HI:
  - pad_clk=1 for CLK_DIV cycles.
  - Then idx <= idx+1 and go to READ_LO.
- DONE (one cycle):
  - buttons <= committed raw.
  - pressed <= raw & ~old buttons.
  - valid=1.
  - Go to IDLE next cycle.
- Frame timing: one frame has N_BITS pad_clk low pulses and N_BITS-1 high phases. With start sampled high in cycle 0, valid is high in cycle 1 + 2*CLK_DIV + (2*N_BITS-1)*CLK_DIV.
- Poll timer:
  - While en=1, counts 0..POLL_PERIOD-1 and wraps.
  - On wrap, sets pending, including when busy.
  - en=0 clears the timer and pending; a frame already in progress still completes.
- start while busy: sets pending, so exactly one further frame follows. Multiple requests during one frame collapse into that single frame.
- Back-to-back frames: if POLL_PERIOD is shorter than the frame length, frames run back to back with one IDLE cycle between them. This is legal and needs no error flag.
- Divider: the counter width is $clog2(CLK_DIV+1). It reloads on every state entry.

Optional Feature:
- Macro: SERIAL_PAD_DEBOUNCE_EN.
- When defined:
  - The block keeps the previous frame's raw vector per pad.
  - In DONE, a pad's slice of buttons and pressed updates only if its raw slice equals the previous raw slice. Otherwise that slice, including its pressed bits, is unchanged.
  - valid still pulses on every frame.
  - The previous-raw register resets to 0.
- When undefined: every frame commits directly, as described above. The previous-raw register is not instantiated.

Test Plan:
- Config N_PADS=2, N_BITS=8, CLK_DIV=2. Pad0 drives A and START low (bits 0 and 3); pad1 drives all high. Pulse start at cycle 0 → pad_latch high in cycles 1–4; 8 pad_clk low pulses; valid in cycle 35; buttons=16'h0009; pressed=16'h0009.
- Repeat the same frame → buttons=16'h0009, pressed=16'h0000. Then release A on pad0 and press B on pad1 → buttons=16'h0208, pressed=16'h0200.
- Auto-poll: en=1, POLL_PERIOD=100, CLK_DIV=2 → pad_latch rises at cycles ≈100, 200, 300. start asserted at cycle 10 and 20 of a frame yields exactly one extra frame. Drop en mid-frame → that frame completes, then no more frames.
- Assert reset low at cycle 20 of a frame → immediately pad_latch=0, pad_clk=1, busy=0, buttons=0. No valid pulse. The next start runs a normal frame.
- Config N_BITS=16 (SNES), CLK_DIV=2 → 16 pad_clk low pulses; valid in cycle 67. Bit 15 is sampled on the 16th low phase.
- With SERIAL_PAD_DEBOUNCE_EN: pad0 bit 0 is low in one frame only, between stable all-high frames → buttons stays 0, pressed stays 0. Held low for two frames → bit 0 is set after the second valid.
